controle_ula_8bits: RTL and testbench
=====================================

# controle_ula_8bits

Sequencing and arbitration controller that shares one 8-bit logic/arithmetic datapath between two requesters. It accepts one operation at a time through a per-requester valid/accept handshake and executes it in a registered execute stage. It then holds the result, flags and owner ID until the consumer takes them. The AND path is the existing `unidade_and_8bits` instance; OR, XOR and ADD are computed alongside it inside this block.

## Interface
Parameters:
- none (width fixed at 8 bits, requester count fixed at 2)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[i] = requester i has an operation pending
- op0, op1  in  2 each  opcode of requester 0/1: 00 AND, 01 OR, 10 XOR, 11 ADD
- a0, b0, a1, b1  in  8 each  operands of requester 0/1
- aceito  out  2  one-hot; aceito[i] high for exactly one cycle when requester i's operation is captured
- s  out  8  registered result
- zero  out  1  s == 8'h00
- carry  out  1  ADD carry-out; 0 for logic ops
- dono  out  1  index of the requester that owns the current result
- resp_valido  out  1  result/flags/dono valid
- resp_pronto  in  1  consumer accepts the result

## Operation
- States: OCIOSO, EXECUTA, RESPONDE. Reset state is OCIOSO.
- **OCIOSO**
  - If req != 0: select a winner i and assert aceito[i] combinationally in this cycle.
  - At the clock edge, capture op_i, a_i, b_i and set dono <= i, then go to EXECUTA.
  - If req == 0: stay in OCIOSO.
- **EXECUTA**
  - Compute the result from the captured operands.
  - At the clock edge, register s, zero and carry, then go to RESPONDE.
  - req is ignored in this state; aceito = 0.
- **RESPONDE**
  - resp_valido = 1; s, zero, carry and dono are held stable.
  - When resp_pronto = 1, go to OCIOSO at the edge.
  - Otherwise hold indefinitely (backpressure). aceito = 0.
- **Arithmetic:** ADD is the 9-bit sum {carry, s} = a + b. Overflow wraps modulo 256 and is reported in carry. For AND/OR/XOR, carry = 0.
- **Arbitration:** a one-bit pointer ultimo holds the last granted index and updates on every grant.
  - Only one requester active: it wins.
  - Both requesting: the winner depends on the arbitration option (see Configuration).
- **Requester contract:** hold req[i], op_i, a_i and b_i stable until aceito[i] is seen high. Drop or change them only in the cycle after aceito.
- A req[i] that deasserts before being granted is never executed.
- **Reset (async, any state, including mid-operation):**
  - State returns to OCIOSO and ultimo = 1.
  - Captured operands are discarded.
  - Outputs: s = 0, zero = 0, carry = 0, dono = 0, resp_valido = 0, aceito = 0.

## Timing
- A request seen in cycle N (state OCIOSO) gives aceito in cycle N, EXECUTA in N+1, and resp_valido = 1 from N+2.
- Minimum occupancy is 3 cycles per operation, assuming resp_pronto is already high in N+2.
- A new grant can happen no earlier than the cycle after the RESPONDE handshake.
- resp_valido falls in the cycle after the edge at which resp_valido && resp_pronto.
- s, zero, carry and dono change only at the EXECUTA→RESPONDE edge (dono changes at the grant edge). They keep their values after the handshake until the next operation writes them.
- resp_pronto asserted outside RESPONDE has no effect.

## Configuration
- ULA_ROUND_ROBIN_EN
  - Defined: when both requesters are active, the requester != ultimo wins. After reset, requester 0 wins the first tie.
  - Undefined: fixed priority, requester 0 always wins ties. The ultimo register is still updated but is not used.

## Test plan
- **Single AND:** req=01, op0=00, a0=8'hF0, b0=8'h3C, resp_pronto=1.
  - Expect aceito=01 in the same cycle.
  - Two cycles later: resp_valido=1, s=8'h30, zero=0, carry=0, dono=0.
- **ADD wrap:** req=10, op1=11, a1=8'hFF, b1=8'h01 → s=8'h00, zero=1, carry=1, dono=1.
- **Tie arbitration:** req=11 held continuously, resp_pronto=1.
  - With ULA_ROUND_ROBIN_EN: aceito sequence 01, 10, 01, spaced 3 cycles apart.
  - Without it: 01, 01, 01.
- **Backpressure:** XOR, a=8'hAA, b=8'hFF, resp_pronto=0 for 5 cycles.
  - Expect resp_valido=1 with s=8'h55 held stable.
  - No aceito while req1 is high.
  - After resp_pronto=1 for one cycle: OCIOSO, then aceito=10.
- **Reset mid-operation:** assert rst during EXECUTA of OR 8'h0F|8'hF0.
  - Immediately: s=0, resp_valido=0, aceito=0.
  - After release with req=11: aceito=01.
- **Withdrawn request:** pulse req0 only in a cycle when the state is EXECUTA → no extra operation is ever executed for it.

Source files
------------

// File: rtl/controle_ula_8bits_if.sv
// Requester/consumer bus of the shared 8-bit ALU controller.
//   slave  : controller side (takes requests and operands, drives grant/result)
//   master : requester/consumer side
// Signals: req[1:0], op0/op1[1:0], a0/b0/a1/b1[7:0], aceito[1:0],
//          s[7:0], zero, carry, dono, resp_valido, resp_pronto.
interface controle_ula_8bits_if;
  logic [1:0] req;
  logic [1:0] op0;
  logic [1:0] op1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic [1:0] aceito;
  logic [7:0] s;
  logic       zero;
  logic       carry;
  logic       dono;
  logic       resp_valido;
  logic       resp_pronto;

  modport slave (
    input  req, op0, op1, a0, b0, a1, b1, resp_pronto,
    output aceito, s, zero, carry, dono, resp_valido
  );

  modport master (
    output req, op0, op1, a0, b0, a1, b1, resp_pronto,
    input  aceito, s, zero, carry, dono, resp_valido
  );
endinterface

// File: rtl/controle_ula_8bits.sv
// Controller sharing one 8-bit AND/OR/XOR/ADD datapath between two requesters.
// Grants one operation at a time (aceito, combinational in OCIOSO), executes it
// in a registered stage, then holds s/zero/carry/dono until resp_pronto.
// Ports: clk, rst (async, active-high), bus (controle_ula_8bits_if.slave).
// Option: define ULA_ROUND_ROBIN_EN for round-robin tie breaking; otherwise
// requester 0 wins every tie.

// Bitwise AND slice of the datapath.
module unidade_and_8bits (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_s
);
  assign o_s = i_a & i_b;
endmodule

module controle_ula_8bits (
  input  logic                 clk,
  input  logic                 rst,
  controle_ula_8bits_if.slave  bus
);
  localparam int unsigned W = 8;

`ifdef ULA_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } t_estado;

  t_estado        r_estado;
  t_estado        w_prox_estado;
  logic           r_ultimo;
  logic [1:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_s;
  logic           r_zero;
  logic           r_carry;
  logic           r_dono;

  logic           w_vencedor;
  logic           w_concede;
  logic [1:0]     w_aceito;
  logic [W-1:0]   w_and;
  logic [W:0]     w_soma;
  logic [W-1:0]   w_res;
  logic           w_carry;

  unidade_and_8bits u_and (
    .i_a (r_a),
    .i_b (r_b),
    .o_s (w_and)
  );

  // Winner selection; on a tie the pointer only matters with round-robin on.
  always_comb begin
    w_vencedor = 1'b0;
    if (bus.req == 2'b11) begin
      w_vencedor = RR_EN & ~r_ultimo;
    end else if (bus.req == 2'b10) begin
      w_vencedor = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next state and grant.
  always_comb begin
    w_prox_estado = r_estado;
    w_aceito      = 2'b00;
    w_concede     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (bus.req != 2'b00) begin
          w_concede            = 1'b1;
          w_aceito[w_vencedor] = 1'b1;
          w_prox_estado        = EXECUTA;
        end
      end
      EXECUTA:  w_prox_estado = RESPONDE;
      RESPONDE: begin
        if (bus.resp_pronto) begin
          w_prox_estado = OCIOSO;
        end
      end
      default:  w_prox_estado = OCIOSO;
    endcase
  end

  // Datapath on the captured operands.
  always_comb begin
    w_soma  = {1'b0, r_a} + {1'b0, r_b};
    w_res   = w_and;
    w_carry = 1'b0;
    case (r_op)
      2'b00: w_res = w_and;
      2'b01: w_res = r_a | r_b;
      2'b10: w_res = r_a ^ r_b;
      2'b11: begin
        w_res   = w_soma[W-1:0];
        w_carry = w_soma[W];
      end
      default: w_res = w_and;
    endcase
  end

  // Operand capture at the grant edge, result capture leaving EXECUTA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ultimo <= 1'b1;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_dono   <= 1'b0;
    end else begin
      if (w_concede) begin
        r_ultimo <= w_vencedor;
        r_dono   <= w_vencedor;
        r_op     <= w_vencedor ? bus.op1 : bus.op0;
        r_a      <= w_vencedor ? bus.a1  : bus.a0;
        r_b      <= w_vencedor ? bus.b1  : bus.b0;
      end
      if (r_estado == EXECUTA) begin
        r_s     <= w_res;
        r_zero  <= (w_res == W'(0));
        r_carry <= w_carry;
      end
    end
  end

  assign bus.aceito      = w_aceito;
  assign bus.s           = r_s;
  assign bus.zero        = r_zero;
  assign bus.carry       = r_carry;
  assign bus.dono        = r_dono;
  assign bus.resp_valido = (r_estado == RESPONDE);
endmodule

// File: tb/tb_controle_ula_8bits.sv
// Directed bench for controle_ula_8bits: AND, ADD wrap, tie arbitration,
// backpressure, reset mid-operation and a withdrawn request.
module tb_controle_ula_8bits;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  controle_ula_8bits_if bus ();

  controle_ula_8bits dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] tie_exp [3];
  logic [7:0] tie_s   [3];

  initial begin
    total = 0;
    bad   = 0;
`ifdef ULA_ROUND_ROBIN_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
    tie_s[0]   = 8'h3F; tie_s[1]   = 8'h03; tie_s[2]   = 8'h3F;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01;
    tie_s[0]   = 8'h3F; tie_s[1]   = 8'h3F; tie_s[2]   = 8'h3F;
`endif

    rst = 1'b1;
    bus.req = 2'b00; bus.op0 = 2'b00; bus.op1 = 2'b00;
    bus.a0 = 8'h00; bus.b0 = 8'h00; bus.a1 = 8'h00; bus.b1 = 8'h00;
    bus.resp_pronto = 1'b0;
    cyc(); cyc();
    chk("rst_s", bus.s, 8'h00);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_dono", bus.dono, 1'b0);
    chk("rst_valido", bus.resp_valido, 1'b0);
    chk("rst_aceito", bus.aceito, 2'b00);
    rst = 1'b0;
    cyc();

    // Single AND
    bus.req = 2'b01; bus.op0 = 2'b00; bus.a0 = 8'hF0; bus.b0 = 8'h3C;
    bus.resp_pronto = 1'b1;
    #1;
    chk("and_aceito", bus.aceito, 2'b01);
    cyc();
    bus.req = 2'b00;
    #1;
    chk("and_exec_aceito", bus.aceito, 2'b00);
    chk("and_exec_valido", bus.resp_valido, 1'b0);
    cyc();
    chk("and_valido", bus.resp_valido, 1'b1);
    chk("and_s", bus.s, 8'h30);
    chk("and_zero", bus.zero, 1'b0);
    chk("and_carry", bus.carry, 1'b0);
    chk("and_dono", bus.dono, 1'b0);
    cyc();
    chk("and_valido_fall", bus.resp_valido, 1'b0);
    chk("and_s_hold", bus.s, 8'h30);

    // ADD wrap
    bus.req = 2'b10; bus.op1 = 2'b11; bus.a1 = 8'hFF; bus.b1 = 8'h01;
    #1;
    chk("add_aceito", bus.aceito, 2'b10);
    cyc();
    bus.req = 2'b00;
    cyc();
    chk("add_valido", bus.resp_valido, 1'b1);
    chk("add_s", bus.s, 8'h00);
    chk("add_zero", bus.zero, 1'b1);
    chk("add_carry", bus.carry, 1'b1);
    chk("add_dono", bus.dono, 1'b1);
    cyc();

    // Tie arbitration with req=11 held
    bus.req = 2'b11;
    bus.op0 = 2'b01; bus.a0 = 8'h0F; bus.b0 = 8'h30;
    bus.op1 = 2'b00; bus.a1 = 8'hC3; bus.b1 = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("tie%0d_aceito", i), bus.aceito, tie_exp[i]);
      cyc();
      chk($sformatf("tie%0d_exec_aceito", i), bus.aceito, 2'b00);
      cyc();
      chk($sformatf("tie%0d_resp_aceito", i), bus.aceito, 2'b00);
      chk($sformatf("tie%0d_valido", i), bus.resp_valido, 1'b1);
      chk($sformatf("tie%0d_dono", i), bus.dono, tie_exp[i][1]);
      chk($sformatf("tie%0d_s", i), bus.s, tie_s[i]);
      cyc();
    end
    bus.req = 2'b00;
    cyc();

    // Backpressure on XOR, requester 1 waiting
    bus.req = 2'b01; bus.op0 = 2'b10; bus.a0 = 8'hAA; bus.b0 = 8'hFF;
    bus.resp_pronto = 1'b0;
    #1;
    chk("bp_aceito", bus.aceito, 2'b01);
    cyc();
    bus.req = 2'b10; bus.op1 = 2'b11; bus.a1 = 8'h10; bus.b1 = 8'h20;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valido", i), bus.resp_valido, 1'b1);
      chk($sformatf("bp%0d_s", i), bus.s, 8'h55);
      chk($sformatf("bp%0d_aceito", i), bus.aceito, 2'b00);
      cyc();
    end
    bus.resp_pronto = 1'b1;
    #1;
    chk("bp_still_valido", bus.resp_valido, 1'b1);
    cyc();
    chk("bp_ocioso_valido", bus.resp_valido, 1'b0);
    chk("bp_aceito_r1", bus.aceito, 2'b10);
    cyc();
    bus.req = 2'b00;
    cyc();
    chk("bp_add_s", bus.s, 8'h30);
    chk("bp_add_carry", bus.carry, 1'b0);
    chk("bp_add_dono", bus.dono, 1'b1);
    cyc();

    // Reset during EXECUTA of OR
    bus.req = 2'b01; bus.op0 = 2'b01; bus.a0 = 8'h0F; bus.b0 = 8'hF0;
    #1;
    chk("rm_aceito", bus.aceito, 2'b01);
    cyc();
    bus.req = 2'b00;
    rst = 1'b1;
    #1;
    chk("rm_s", bus.s, 8'h00);
    chk("rm_valido", bus.resp_valido, 1'b0);
    chk("rm_aceito0", bus.aceito, 2'b00);
    chk("rm_dono", bus.dono, 1'b0);
    cyc();
    rst = 1'b0;
    bus.req = 2'b11;
    #1;
    chk("rm_tie_aceito", bus.aceito, 2'b01);
    cyc();
    bus.req = 2'b00;
    cyc();
    chk("rm_or_s", bus.s, 8'hFF);
    chk("rm_or_zero", bus.zero, 1'b0);
    cyc();

    // Withdrawn request during EXECUTA
    bus.req = 2'b10; bus.op1 = 2'b10; bus.a1 = 8'h0F; bus.b1 = 8'h0F;
    #1;
    chk("wd_aceito", bus.aceito, 2'b10);
    cyc();
    bus.req = 2'b01;
    #1;
    chk("wd_exec_aceito", bus.aceito, 2'b00);
    cyc();
    bus.req = 2'b00;
    chk("wd_s", bus.s, 8'h00);
    chk("wd_zero", bus.zero, 1'b1);
    chk("wd_dono", bus.dono, 1'b1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wd%0d_valido", i), bus.resp_valido, 1'b0);
      chk($sformatf("wd%0d_aceito", i), bus.aceito, 2'b00);
      chk($sformatf("wd%0d_dono", i), bus.dono, 1'b1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
